// File: rtl/forward_hazard_unit_pkg.sv
// Shared types for the operand-forwarding / hazard control block.
package forward_hazard_unit_pkg;

  localparam int unsigned REG_AW = 5;

  // EX-stage forward mux select encodings; 2'b11 is never produced.
  typedef enum logic [1:0] {
    NOforward  = 2'b00,
    forwardMEM = 2'b01,
    forwardWB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_e;

  // Shadow copy of the destination info of one in-flight instruction.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wren;
    logic              is_load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: {REG_AW{1'b0}}, wren: 1'b0, is_load: 1'b0};

  // True when the slot will write register addr (x0 is never a producer).
  function automatic logic slot_writes(input slot_t slot, input logic [REG_AW-1:0] addr);
    return slot.valid && slot.wren && (slot.rd != {REG_AW{1'b0}}) && (slot.rd == addr);
  endfunction

endpackage

// File: rtl/forward_hazard_unit_fwd_match.sv
// Per-operand forward select: youngest producer (EX) wins over MEM.
module forward_hazard_unit_fwd_match
  import forward_hazard_unit_pkg::*;
(
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic              src_used_i,
  input  slot_t             ex_slot_i,
  input  slot_t             mem_slot_i,
  output logic [1:0]        sel_o
);

  // The load flag only matters for load-use detection, not for forwarding.
  logic unused_s;
  assign unused_s = ex_slot_i.is_load ^ mem_slot_i.is_load;

  // Pick the forward source for one operand.
  always_comb begin
    sel_o = NOforward;
    if (!src_used_i) begin
      sel_o = NOforward;
    end else if (slot_writes(ex_slot_i, src_addr_i)) begin
      sel_o = forwardMEM;
    end else if (slot_writes(mem_slot_i, src_addr_i)) begin
      sel_o = forwardWB;
    end else begin
      sel_o = NOforward;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Producer-side forwarding and hazard control for the 5-stage RV32I pipeline.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ID_valid_i,
  input  logic [REG_AW-1:0] ID_rs1_addr_i,
  input  logic [REG_AW-1:0] ID_rs2_addr_i,
  input  logic              ID_rs1_used_i,
  input  logic              ID_rs2_used_i,
  input  logic [REG_AW-1:0] ID_rd_addr_i,
  input  logic              ID_rd_wren_i,
  input  logic              ID_is_load_i,
  input  logic              EX_branch_taken_i,
  input  logic              MEM_ready_i,
  output logic [1:0]        forward_rs1_sel_o,
  output logic [1:0]        forward_rs2_sel_o,
  output logic              stall_pc_o,
  output logic              stall_id_o,
  output logic              flush_id_o,
  output logic              bubble_ex_o,
  output logic              freeze_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  state_e            state_q, state_d;
  slot_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0]        rs1_sel_q, rs1_sel_d, rs2_sel_q, rs2_sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              freeze_s, load_use_s, branch_s, stall_s, bubble_s;
  logic [1:0]        rs1_match_s, rs2_match_s;

  // WB slot is tracked for completeness; the register file covers it.
  logic unused_s;
  assign unused_s = ^{wb_q, mem_q.is_load};

  forward_hazard_unit_fwd_match u_fwd_match_rs1 (
    .src_addr_i (ID_rs1_addr_i),
    .src_used_i (ID_valid_i & ID_rs1_used_i),
    .ex_slot_i  (ex_q),
    .mem_slot_i (mem_q),
    .sel_o      (rs1_match_s)
  );

  forward_hazard_unit_fwd_match u_fwd_match_rs2 (
    .src_addr_i (ID_rs2_addr_i),
    .src_used_i (ID_valid_i & ID_rs2_used_i),
    .ex_slot_i  (ex_q),
    .mem_slot_i (mem_q),
    .sel_o      (rs2_match_s)
  );

  // Memory busy: entering the freeze needs a valid MEM slot; once frozen the slot is held.
  always_comb begin
    case (state_q)
      RUN:     freeze_s = mem_q.valid & ~MEM_ready_i;
      FREEZE:  freeze_s = ~MEM_ready_i;
      default: freeze_s = 1'b0;
    endcase
  end

  // Load-use detection against the load currently in EX.
  always_comb begin
    load_use_s = 1'b0;
    if (ID_valid_i && ex_q.is_load) begin
      load_use_s = (ID_rs1_used_i && slot_writes(ex_q, ID_rs1_addr_i)) ||
                   (ID_rs2_used_i && slot_writes(ex_q, ID_rs2_addr_i));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Freeze overrides everything; a taken branch overrides load-use.
  assign branch_s = EX_branch_taken_i & ~freeze_s;
  assign stall_s  = load_use_s & ~EX_branch_taken_i & ~freeze_s;
  assign bubble_s = branch_s | stall_s;

  // Next-state for slots, selects, counter and FSM.
  always_comb begin
    state_d   = freeze_s ? FREEZE : RUN;
    ex_d      = ex_q;
    mem_d     = mem_q;
    wb_d      = wb_q;
    rs1_sel_d = rs1_sel_q;
    rs2_sel_d = rs2_sel_q;
    cnt_d     = cnt_q;
    if (!freeze_s) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (bubble_s || !ID_valid_i) begin
        ex_d = SLOT_EMPTY;
      end else begin
        ex_d = '{valid: 1'b1, rd: ID_rd_addr_i, wren: ID_rd_wren_i, is_load: ID_is_load_i};
      end
      if (bubble_s) begin
        rs1_sel_d = NOforward;
        rs2_sel_d = NOforward;
      end else begin
        rs1_sel_d = rs1_match_s;
        rs2_sel_d = rs2_match_s;
      end
    end else begin
      ex_d = ex_q;
    end
    if ((stall_s || freeze_s) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline shadow state, FSM and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      ex_q      <= SLOT_EMPTY;
      mem_q     <= SLOT_EMPTY;
      wb_q      <= SLOT_EMPTY;
      rs1_sel_q <= NOforward;
      rs2_sel_q <= NOforward;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      rs1_sel_q <= rs1_sel_d;
      rs2_sel_q <= rs2_sel_d;
      cnt_q     <= cnt_d;
    end
  end

  assign forward_rs1_sel_o = rs1_sel_q;
  assign forward_rs2_sel_o = rs2_sel_q;
  assign stall_pc_o        = stall_s;
  assign stall_id_o        = stall_s;
  assign flush_id_o        = branch_s;
  assign bubble_ex_o       = bubble_s;
  assign freeze_o          = freeze_s;
  assign stall_cnt_o       = cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench: directed vector table, freeze/reset sequences, random vs model.
module tb_forward_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        idv = 1'b0, u1 = 1'b0, u2 = 1'b0, wr = 1'b0, ld = 1'b0, br = 1'b0, rdy = 1'b1;
  logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic [1:0]  s1_o, s2_o;
  logic        spc_o, sid_o, fl_o, bub_o, frz_o;
  logic [31:0] cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  forward_hazard_unit #(.CNT_W(32)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .ID_valid_i        (idv),
    .ID_rs1_addr_i     (rs1),
    .ID_rs2_addr_i     (rs2),
    .ID_rs1_used_i     (u1),
    .ID_rs2_used_i     (u2),
    .ID_rd_addr_i      (rd),
    .ID_rd_wren_i      (wr),
    .ID_is_load_i      (ld),
    .EX_branch_taken_i (br),
    .MEM_ready_i       (rdy),
    .forward_rs1_sel_o (s1_o),
    .forward_rs2_sel_o (s2_o),
    .stall_pc_o        (spc_o),
    .stall_id_o        (sid_o),
    .flush_id_o        (fl_o),
    .bubble_ex_o       (bub_o),
    .freeze_o          (frz_o),
    .stall_cnt_o       (cnt_o)
  );

  // One cycle of stimulus with the outputs expected during that cycle.
  // ctl = {stall_pc, stall_id, flush_id, bubble_ex, freeze}
  typedef struct {
    logic       idv;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr, ld, br, rdy;
    logic [1:0] s1, s2;
    logic [4:0] ctl;
    int         cnt;
  } vec_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } rec_t;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_LU   = 5'b11010;
  localparam logic [4:0] C_BR   = 5'b00110;
  localparam logic [4:0] C_FRZ  = 5'b00001;

  vec_t tbl[27];
  vec_t fseq[7];

  function automatic vec_t mk(input logic iv, input logic [4:0] a1, input logic f1,
                              input logic [4:0] a2, input logic f2, input logic [4:0] d,
                              input logic w, input logic l, input logic b, input logic r,
                              input logic [1:0] e1, input logic [1:0] e2,
                              input logic [4:0] c, input int n);
    vec_t v;
    v.idv = iv; v.rs1 = a1; v.u1 = f1; v.rs2 = a2; v.u2 = f2; v.rd = d;
    v.wr = w; v.ld = l; v.br = b; v.rdy = r; v.s1 = e1; v.s2 = e2; v.ctl = c; v.cnt = n;
    return v;
  endfunction

  task automatic chk(input string tag, input int idx, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d].%s got=%0h want=%0h", tag, idx, what, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx, input logic [1:0] e1,
                            input logic [1:0] e2, input logic [4:0] c, input logic [31:0] n);
    chk(tag, idx, "rs1_sel",   {30'd0, s1_o}, {30'd0, e1});
    chk(tag, idx, "rs2_sel",   {30'd0, s2_o}, {30'd0, e2});
    chk(tag, idx, "stall_pc",  {31'd0, spc_o}, {31'd0, c[4]});
    chk(tag, idx, "stall_id",  {31'd0, sid_o}, {31'd0, c[3]});
    chk(tag, idx, "flush_id",  {31'd0, fl_o},  {31'd0, c[2]});
    chk(tag, idx, "bubble_ex", {31'd0, bub_o}, {31'd0, c[1]});
    chk(tag, idx, "freeze",    {31'd0, frz_o}, {31'd0, c[0]});
    chk(tag, idx, "stall_cnt", cnt_o, n);
  endtask

  task automatic run_row(input string tag, input int idx, input vec_t v);
    @(negedge clk);
    idv = v.idv; rs1 = v.rs1; u1 = v.u1; rs2 = v.rs2; u2 = v.u2;
    rd = v.rd; wr = v.wr; ld = v.ld; br = v.br; rdy = v.rdy;
    #1;
    check_outs(tag, idx, v.s1, v.s2, v.ctl, v.cnt);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic reset_check(input int idx);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    idv = 1'b0; u1 = 1'b0; u2 = 1'b0; wr = 1'b0; ld = 1'b0; br = 1'b0; rdy = 1'b1;
    #1;
    check_outs("reset", idx, 2'b00, 2'b00, C_NONE, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic hit(input rec_t r, input logic [4:0] a);
    return r.v && r.wr && (r.rd != 5'd0) && (r.rd == a);
  endfunction

  function automatic logic [1:0] pick(input rec_t ex, input rec_t mem, input logic [4:0] a,
                                      input logic used);
    if (!used)          return 2'd0;
    if (hit(ex, a))     return 2'd1;
    if (hit(mem, a))    return 2'd2;
    return 2'd0;
  endfunction

  // Random stimulus against a queue-based model of the in-flight instructions.
  task automatic run_random(input int cycles);
    rec_t        pq[$];
    rec_t        ex_r, mem_r, nw;
    logic [1:0]  m_s1, m_s2;
    logic [31:0] m_cnt;
    logic        m_frz, m_lu, m_br, m_st;
    pq = '{3{rec_t'(8'd0)}};
    m_s1 = 2'd0; m_s2 = 2'd0; m_cnt = 32'd0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      idv = ($urandom_range(0, 9) < 8);
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      u1  = ($urandom_range(0, 9) < 7); u2 = ($urandom_range(0, 9) < 7);
      wr  = ($urandom_range(0, 9) < 8); ld = ($urandom_range(0, 9) < 3);
      br  = ($urandom_range(0, 9) < 1); rdy = ($urandom_range(0, 9) < 7);
      #1;
      ex_r  = pq[0];
      mem_r = pq[1];
      m_frz = mem_r.v && !rdy;
      m_lu  = idv && ex_r.v && ex_r.ld && ((u1 && hit(ex_r, rs1)) || (u2 && hit(ex_r, rs2)));
      m_br  = br && !m_frz;
      m_st  = m_lu && !br && !m_frz;
      check_outs("rand", c, m_s1, m_s2, {m_st, m_st, m_br, m_br | m_st, m_frz}, m_cnt);
      if ((m_st || m_frz) && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
      if (!m_frz) begin
        m_s1 = (m_br || m_st) ? 2'd0 : pick(ex_r, mem_r, rs1, idv && u1);
        m_s2 = (m_br || m_st) ? 2'd0 : pick(ex_r, mem_r, rs2, idv && u2);
        nw.v = idv && !m_br && !m_st; nw.rd = rd; nw.wr = wr; nw.ld = ld;
        pq.push_front(nw);
        pq.delete(3);
      end
    end
  endtask

  initial begin
    //             idv rs1  u1 rs2  u2 rd   wr ld br rdy  s1     s2     ctl     cnt
    tbl[0]  = mk(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0, 0, 1, 2'b00, 2'b00, C_NONE, 0); // addi x5
    tbl[1]  = mk(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, 1, 2'b00, 2'b00, C_NONE, 0); // add x6,x5,x7
    tbl[2]  = mk(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 1, 2'b01, 2'b00, C_NONE, 0); // nop; EX->MEM fwd
    tbl[3]  = mk(1, 5'd0, 1, 5'd0, 0, 5'd10,1, 0, 0, 1, 2'b00, 2'b00, C_NONE, 0); // addi x10
    tbl[4]  = mk(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 1, 2'b00, 2'b00, C_NONE, 0); // nop
    tbl[5]  = mk(1, 5'd7, 1, 5'd10,1, 5'd6, 1, 0, 0, 1, 2'b00, 2'b00, C_NONE, 0); // add x6,x7,x10
    tbl[6]  = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 2'b00, 2'b10, C_NONE, 0); // WB fwd on rs2
    tbl[7]  = mk(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 1, 2'b00, 2'b00, C_NONE, 0); // lw x8
    tbl[8]  = mk(1, 5'd8, 1, 5'd8, 1, 5'd9, 1, 0, 0, 1, 2'b00, 2'b00, C_LU,   0); // add x9,x8,x8 stalls
    tbl[9]  = mk(1, 5'd8, 1, 5'd8, 1, 5'd9, 1, 0, 0, 1, 2'b00, 2'b00, C_NONE, 1); // single stall cycle
    tbl[10] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 2'b10, 2'b10, C_NONE, 1); // both from WB
    tbl[11] = mk(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 1, 2'b00, 2'b00, C_NONE, 1); // lw x8
    tbl[12] = mk(1, 5'd8, 1, 5'd8, 1, 5'd9, 1, 0, 1, 1, 2'b00, 2'b00, C_BR,   1); // branch beats LU
    tbl[13] = mk(1, 5'd9, 1, 5'd8, 1, 5'd3, 1, 0, 0, 1, 2'b00, 2'b00, C_NONE, 1); // add x3,x9,x8
    tbl[14] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 2'b00, 2'b10, C_NONE, 1); // EX was empty
    tbl[15] = mk(1, 5'd0, 1, 5'd0, 0, 5'd20,1, 0, 0, 1, 2'b00, 2'b00, C_NONE, 1); // addi x20
    tbl[16] = mk(1, 5'd20,1, 5'd0, 0, 5'd8, 1, 1, 0, 1, 2'b00, 2'b00, C_NONE, 1); // lw x8,0(x20)
    tbl[17] = mk(1, 5'd20,1, 5'd0, 0, 5'd21,1, 0, 0, 1, 2'b01, 2'b00, C_NONE, 1); // add x21,x20
    tbl[18] = mk(1, 5'd21,1, 5'd8, 1, 5'd22,1, 0, 0, 0, 2'b10, 2'b00, C_FRZ,  1); // freeze 1
    tbl[19] = mk(1, 5'd21,1, 5'd8, 1, 5'd22,1, 0, 0, 0, 2'b10, 2'b00, C_FRZ,  2); // freeze 2
    tbl[20] = mk(1, 5'd21,1, 5'd8, 1, 5'd22,1, 0, 0, 0, 2'b10, 2'b00, C_FRZ,  3); // freeze 3
    tbl[21] = mk(1, 5'd21,1, 5'd8, 1, 5'd22,1, 0, 0, 1, 2'b10, 2'b00, C_NONE, 4); // ready
    tbl[22] = mk(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 1, 2'b01, 2'b10, C_NONE, 4); // nop
    tbl[23] = mk(1, 5'd0, 1, 5'd0, 1, 5'd23,1, 0, 0, 1, 2'b00, 2'b00, C_NONE, 4); // add x23,x0,x0
    tbl[24] = mk(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 1, 0, 1, 2'b00, 2'b00, C_NONE, 4); // lw x0
    tbl[25] = mk(1, 5'd0, 1, 5'd0, 1, 5'd1, 1, 0, 0, 1, 2'b00, 2'b00, C_NONE, 4); // x0 never stalls
    tbl[26] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 2'b00, 2'b00, C_NONE, 4);

    fseq[0] = mk(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0, 1, 2'b00, 2'b00, C_NONE, 0); // lw x8
    fseq[1] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 2'b00, 2'b00, C_NONE, 0);
    fseq[2] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00, C_FRZ,  0);
    fseq[3] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00, C_FRZ,  1);
    fseq[4] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00, C_FRZ,  2);
    fseq[5] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 2'b00, 2'b00, C_NONE, 3);
    fseq[6] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 2'b00, 2'b00, C_NONE, 3);

    // Power-on reset.
    repeat (2) @(negedge clk);
    #1;
    check_outs("por", 0, 2'b00, 2'b00, C_NONE, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) run_row("vec", i, tbl[i]);

    reset_check(1);
    for (int i = 0; i < 7; i++) run_row("freeze", i, fseq[i]);

    reset_check(2);
    run_random(1500);

    reset_check(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
